mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Sequences the external memory bus (mem_rd/mem_wr strobes) for the CPU.
//  Arbitrates between two requesters: the control unit's instruction fetch
//  port and its data load/store port. One access is in flight at a time.
//  Each access waits for a mem_ready handshake and is bounded by a timeout.
//  Returns read data and a one-cycle ack to the winning requester.
// PARAMETERS
//  ADDR_WIDTH  32   width of all address ports
//  DATA_WIDTH  32   width of all data ports
//  TIMEOUT     255  max ACCESS cycles without mem_ready before abort; 0 = never time out
// PORTS
//  clk         in   1   system clock; all state updates on rising edge
//  rst         in   1   synchronous, active-high reset
//  fetch_req   in   1   fetch request; held high until fetch_ack
//  fetch_addr  in   AW  fetch address
//  fetch_ack   out  1   one-cycle pulse: fetch complete
//  fetch_data  out  DW  fetched word; valid while fetch_ack=1
//  data_req    in   1   data request; held high until data_ack
//  data_wr     in   1   1 = store, 0 = load
//  data_addr   in   AW  data address
//  data_wdata  in   DW  store data
//  data_ack    out  1   one-cycle pulse: data access complete
//  data_rdata  out  DW  load data; valid while data_ack=1
//  mem_addr    out  AW  address to memory
//  mem_wdata   out  DW  write data to memory
//  mem_rdata   in   DW  read data from memory
//  mem_rd      out  1   read strobe
//  mem_wr      out  1   write strobe
//  mem_ready   in   1   memory completes the access when high
//  bus_err     out  1   one-cycle pulse with the ack when an access timed out
//  busy        out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; wait count 0; starve count 0.
//  All outputs are registered.
//  FSM states:
//   IDLE:   if any req is high, grant one and latch addr, wdata and wr
//           into mem_addr/mem_wdata/op; go to ACCESS. Otherwise stay.
//   ACCESS: mem_rd = !op_wr, mem_wr = op_wr.
//           If mem_ready: capture mem_rdata; go to RESP.
//           Else if TIMEOUT != 0 and wait count == TIMEOUT-1: go to RESP with err.
//           Otherwise increment the wait count.
//   RESP:   strobes 0; the granted ack pulses for this one cycle;
//           bus_err = err; go to IDLE.
//  Arbitration (in IDLE only):
//   - data wins over fetch, unless fetch has lost 2 consecutive arbitrations
//     while pending (starve count == 2); then fetch wins.
//   - starve count resets to 0 whenever fetch is granted or fetch_req is low.
//  Latency:
//   - req high in IDLE cycle n -> strobe in cycle n+1.
//   - If mem_ready is already high in n+1, ack is in n+2.
//   - Each wait state adds one cycle.
//  Data outputs:
//   - fetch_data/data_rdata hold the last captured word until the next capture.
//   - Loads only: a timed-out load returns 0. Stores never update rdata.
//  Boundaries:
//   - req dropped during ACCESS: the access still completes and is acked.
//   - Requester must drop req the edge after ack, or a new access starts.
//   - mem_ready high in IDLE or RESP: ignored.
//   - Both reqs high in the same cycle: arbitrated as above; the loser
//     stays pending.
//   - rst during ACCESS or RESP: next edge -> IDLE, strobes 0, no ack,
//     no bus_err.
//   - The wait count is AW-independent: width $clog2(TIMEOUT+1), min 1.
//     It clears on entering ACCESS.
// STRUCTURE
//  mem_pkg: typedef enum logic [1:0] {IDLE, ACCESS, RESP} mem_state_e;
//           typedef enum logic {GRANT_FETCH, GRANT_DATA} mem_grant_e;
//           localparam STARVE_LIMIT = 2.
//  Sub-module wait_timer: load/clear, enable, terminal-count flag, parameterised by TIMEOUT.
//  Arbitration decision and the FSM stay in mem_arbiter.
// TESTING
//  1 fetch_req, addr=0x10; mem_ready=1 immediately; mem_rdata=0xDEADBEEF
//    -> mem_rd high for 1 cycle; fetch_ack at req+2; fetch_data=0xDEADBEEF.
//  2 data store, addr=0x20, wdata=0x1234; mem_ready after 3 waits
//    -> mem_wr high for 4 cycles; data_ack at req+5; data_rdata unchanged.
//  3 fetch_req and data_req held continuously
//    -> grant order data, data, fetch, data, data, fetch...; no req starves.
//  4 TIMEOUT=4; load with mem_ready=0 -> mem_rd high for exactly 4 cycles;
//    then data_ack and bus_err pulse together; data_rdata=0.
//  5 rst asserted in the 2nd ACCESS cycle -> next cycle: mem_rd=0, busy=0,
//    no ack; a fresh fetch afterwards completes normally.
//  6 data_req dropped mid-ACCESS; mem_ready=1
//    -> data_ack still pulses once; no second access.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory bus arbiter.
package mem_pkg;

  // Bus sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } mem_state_e;

  // Which requester owns the access currently in flight.
  typedef enum logic {
    GRANT_FETCH,
    GRANT_DATA
  } mem_grant_e;

  // Consecutive arbitration losses a pending fetch tolerates before it is forced through.
  localparam int unsigned STARVE_LIMIT = 2;
  localparam int unsigned STARVE_W     = 2;

endpackage

// File: rtl/wait_timer.sv
// Counts ACCESS wait cycles and flags the last cycle allowed before an abort.
module wait_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);

  // A TIMEOUT of 0 disables the abort, but the counter keeps at least one bit.
  localparam int unsigned           CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]      LAST_CNT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Wait counter: held at zero outside ACCESS, advances on each cycle without mem_ready.
  // NOTE: sequential state is written with <= so every flop samples its pre-edge inputs.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (TIMEOUT != 0) && (count == LAST_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data ports onto a single external memory bus,
// one access at a time, with a mem_ready handshake and a wait timeout.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ack,
  output logic [DATA_WIDTH-1:0] fetch_data,
  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_ack,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  input  logic                  mem_ready,
  output logic                  bus_err,
  output logic                  busy
);

  mem_state_e           state;
  mem_grant_e           grant;
  logic                 op_wr;
  logic [STARVE_W-1:0]  starve_cnt;

  logic                 fetch_wins;
  logic                 timer_clear;
  logic                 timer_en;
  logic                 timer_tc;
  logic                 timed_out;

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .en    (timer_en),
    .tc    (timer_tc)
  );

  // Arbitration decision and wait-timer control for the current cycle.
  // NOTE: every signal gets a default first so no path through this block infers a latch.
  always_comb begin
    fetch_wins  = 1'b0;
    timer_clear = 1'b1;
    timer_en    = 1'b0;
    timed_out   = 1'b0;

    fetch_wins  = fetch_req && (!data_req || (starve_cnt == STARVE_W'(STARVE_LIMIT)));
    timer_clear = (state != ACCESS);
    timer_en    = (state == ACCESS) && !mem_ready;
    timed_out   = (state == ACCESS) && !mem_ready && timer_tc;
  end

  // Starvation tracking: counts arbitrations a pending fetch loses to data.
  always_ff @(posedge clk) begin
    if (rst || !fetch_req) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      starve_cnt <= fetch_wins ? '0 : starve_cnt + STARVE_W'(1);
    end
  end

  // Bus sequencer with registered strobes, acks, error flag and read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= GRANT_FETCH;
      op_wr      <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      fetch_ack  <= 1'b0;
      fetch_data <= '0;
      data_ack   <= 1'b0;
      data_rdata <= '0;
      bus_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_req || data_req) begin
            state <= ACCESS;
            busy  <= 1'b1;
            if (fetch_wins) begin
              grant     <= GRANT_FETCH;
              op_wr     <= 1'b0;
              mem_addr  <= fetch_addr;
              mem_wdata <= '0;
              mem_rd    <= 1'b1;
              mem_wr    <= 1'b0;
            end else begin
              grant     <= GRANT_DATA;
              op_wr     <= data_wr;
              mem_addr  <= data_addr;
              mem_wdata <= data_wdata;
              mem_rd    <= !data_wr;
              mem_wr    <= data_wr;
            end
          end
        end

        ACCESS: begin
          if (mem_ready || timed_out) begin
            state   <= RESP;
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
            bus_err <= !mem_ready;
            if (grant == GRANT_FETCH) begin
              fetch_ack  <= 1'b1;
              fetch_data <= mem_ready ? mem_rdata : '0;
            end else begin
              data_ack <= 1'b1;
              // Stores leave the load-data register untouched.
              if (!op_wr) begin
                data_rdata <= mem_ready ? mem_rdata : '0;
              end
            end
          end
        end

        RESP: begin
          state     <= IDLE;
          busy      <= 1'b0;
          fetch_ack <= 1'b0;
          data_ack  <= 1'b0;
          bus_err   <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (built with TIMEOUT = 4).
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ack;
  logic [DW-1:0] fetch_data;
  logic          data_req;
  logic          data_wr;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_ack;
  logic [DW-1:0] data_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_rd;
  logic          mem_wr;
  logic          mem_ready;
  logic          bus_err;
  logic          busy;

  int n_compared   = 0;
  int n_mismatched = 0;

  mem_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ack  (fetch_ack),
    .fetch_data (fetch_data),
    .data_req   (data_req),
    .data_wr    (data_wr),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_ack   (data_ack),
    .data_rdata (data_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_ready  (mem_ready),
    .bus_err    (bus_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge: outputs are stable, inputs may change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    byte unsigned order[$];
    byte unsigned exp_order[6];
    int           n_acks;

    rst        = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_addr  = '0;
    data_wdata = '0;
    mem_rdata  = '0;
    mem_ready  = 1'b0;
    tick();
    tick();

    // Reset state.
    check("rst_busy",      busy,      0);
    check("rst_mem_rd",    mem_rd,    0);
    check("rst_mem_wr",    mem_wr,    0);
    check("rst_fetch_ack", fetch_ack, 0);
    check("rst_data_ack",  data_ack,  0);
    check("rst_bus_err",   bus_err,   0);
    check("rst_mem_addr",  mem_addr,  0);
    rst = 1'b0;
    tick();

    // 1: fetch, memory ready immediately.
    fetch_req  = 1'b1;
    fetch_addr = 32'h10;
    mem_ready  = 1'b1;
    mem_rdata  = 32'hDEADBEEF;
    tick();
    check("t1_rd_n1",   mem_rd,    1);
    check("t1_addr",    mem_addr,  32'h10);
    check("t1_busy",    busy,      1);
    check("t1_ack_n1",  fetch_ack, 0);
    tick();
    check("t1_rd_n2",   mem_rd,    0);
    check("t1_ack_n2",  fetch_ack, 1);
    check("t1_data",    fetch_data, 32'hDEADBEEF);
    check("t1_err",     bus_err,   0);
    fetch_req = 1'b0;
    mem_ready = 1'b0;
    tick();
    check("t1_ack_off", fetch_ack, 0);
    check("t1_idle",    busy,      0);
    check("t1_hold",    fetch_data, 32'hDEADBEEF);

    // 2: store with three wait states.
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_addr  = 32'h20;
    data_wdata = 32'h1234;
    mem_rdata  = 32'hAAAA5555;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("t2_wr_c%0d", i), mem_wr, 1);
      check($sformatf("t2_rd_c%0d", i), mem_rd, 0);
      check($sformatf("t2_ack_c%0d", i), data_ack, 0);
      if (i == 1) begin
        check("t2_addr",  mem_addr,  32'h20);
        check("t2_wdata", mem_wdata, 32'h1234);
      end
      if (i == 4) mem_ready = 1'b1;
    end
    tick();
    check("t2_ack",    data_ack,   1);
    check("t2_wr_off", mem_wr,     0);
    check("t2_rdata",  data_rdata, 0);
    check("t2_err",    bus_err,    0);
    data_req  = 1'b0;
    data_wr   = 1'b0;
    mem_ready = 1'b0;
    tick();

    // Load that succeeds, so the following timeout visibly clears data_rdata.
    data_req  = 1'b1;
    data_addr = 32'h30;
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    tick();
    check("ld_rd", mem_rd, 1);
    tick();
    check("ld_ack",   data_ack,   1);
    check("ld_rdata", data_rdata, 32'hCAFEF00D);
    data_req  = 1'b0;
    mem_ready = 1'b0;
    tick();

    // 4: load that times out after exactly four ACCESS cycles.
    data_req  = 1'b1;
    data_addr = 32'h40;
    mem_rdata = 32'h55;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("t4_rd_c%0d", i), mem_rd, 1);
      check($sformatf("t4_ack_c%0d", i), data_ack, 0);
    end
    tick();
    check("t4_rd_off", mem_rd,     0);
    check("t4_ack",    data_ack,   1);
    check("t4_err",    bus_err,    1);
    check("t4_rdata",  data_rdata, 0);
    check("t4_fdata",  fetch_data, 32'hDEADBEEF);
    data_req = 1'b0;
    tick();
    check("t4_err_off", bus_err, 0);
    check("t4_ack_off", data_ack, 0);

    // 3: both requesters held; expected grant order D D F D D F.
    exp_order = '{8'h44, 8'h44, 8'h46, 8'h44, 8'h44, 8'h46};
    fetch_req  = 1'b1;
    fetch_addr = 32'h100;
    data_req   = 1'b1;
    data_wr    = 1'b0;
    data_addr  = 32'h200;
    mem_ready  = 1'b1;
    mem_rdata  = 32'h77;
    n_acks     = 0;
    for (int c = 0; c < 60 && n_acks < 6; c++) begin
      tick();
      if (fetch_ack && data_ack) check("t3_dual_ack", 1, 0);
      if (data_ack)  begin order.push_back(8'h44); n_acks++; end
      if (fetch_ack) begin order.push_back(8'h46); n_acks++; end
      if (n_acks >= 6) begin
        fetch_req = 1'b0;
        data_req  = 1'b0;
      end
    end
    fetch_req = 1'b0;
    data_req  = 1'b0;
    mem_ready = 1'b0;
    check("t3_ack_count", n_acks, 6);
    for (int k = 0; k < 6 && k < order.size(); k++)
      check($sformatf("t3_grant_%0d", k), order[k], exp_order[k]);
    tick();
    tick();

    // 5: reset in the second ACCESS cycle, then a fresh fetch.
    fetch_req  = 1'b1;
    fetch_addr = 32'h50;
    tick();
    check("t5_rd_a1", mem_rd, 1);
    tick();
    check("t5_rd_a2", mem_rd, 1);
    rst = 1'b1;
    tick();
    check("t5_rd_rst",   mem_rd,    0);
    check("t5_busy_rst", busy,      0);
    check("t5_ack_rst",  fetch_ack, 0);
    check("t5_err_rst",  bus_err,   0);
    rst       = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h600D;
    tick();
    check("t5_rd_new",   mem_rd,   1);
    check("t5_addr_new", mem_addr, 32'h50);
    tick();
    check("t5_ack_new",  fetch_ack,  1);
    check("t5_data_new", fetch_data, 32'h600D);
    fetch_req = 1'b0;
    mem_ready = 1'b0;
    tick();

    // 6: data_req dropped mid-ACCESS; exactly one ack, no second access.
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_addr = 32'h60;
    tick();
    check("t6_rd_a1", mem_rd, 1);
    data_req = 1'b0;
    tick();
    check("t6_rd_a2", mem_rd, 1);
    mem_ready = 1'b1;
    mem_rdata = 32'h6666;
    tick();
    check("t6_ack",   data_ack,   1);
    check("t6_rdata", data_rdata, 32'h6666);
    n_acks = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (data_ack || fetch_ack || mem_rd || mem_wr) n_acks++;
    end
    check("t6_no_extra", n_acks, 0);
    check("t6_idle",     busy,   0);
    mem_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
